// File: rtl/dispatch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dispatch_ctrl_pkg : shared dispatch types, FSM encoding and width constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef N_WAY
`define N_WAY 3
`endif

package dispatch_ctrl_pkg;

  localparam int DISP_N_WAY             = `N_WAY;
  localparam int DISP_CW                = $clog2(`N_WAY) + 1;
  localparam int RECOVER_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    FLUSH   = 2'd2,
    RECOVER = 2'd3
  } DISP_CTRL_STATE;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic [6:0]   dest_preg;
    logic [DISP_CW-1:0] slot;
  } DISPATCH_PACKET;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [6:0]  dest_preg;
    logic [6:0]  old_preg;
  } ROB_PACKET;

endpackage

`default_nettype wire

// File: rtl/dispatch_ctrl_min4_sat.sv
// ---------------------------------------------------------------------------
// min4_sat : minimum of four resource counts, each saturated to N_WAY first
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module min4_sat #(
  parameter int N_WAY = 3,
  parameter int CW    = $clog2(N_WAY) + 1
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic [CW-1:0] c_i,
  input  logic [CW-1:0] d_i,
  output logic [CW-1:0] min_o
);

  localparam logic [CW-1:0] MAXV = CW'(N_WAY);

  logic [CW-1:0] a_s;
  logic [CW-1:0] b_s;
  logic [CW-1:0] c_s;
  logic [CW-1:0] d_s;
  logic [CW-1:0] ab_min;
  logic [CW-1:0] cd_min;

  always_comb begin
    a_s    = (a_i > MAXV) ? MAXV : a_i;
    b_s    = (b_i > MAXV) ? MAXV : b_i;
    c_s    = (c_i > MAXV) ? MAXV : c_i;
    d_s    = (d_i > MAXV) ? MAXV : d_i;
    ab_min = (a_s < b_s) ? a_s : b_s;
    cd_min = (c_s < d_s) ? c_s : d_s;
    min_o  = (ab_min < cd_min) ? ab_min : cd_min;
  end

endmodule

`default_nettype wire

// File: rtl/dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// dispatch_ctrl : superscalar dispatch grant and branch-recovery sequencer.
// Optional statistics counters enabled by DISPATCH_CTRL_STATS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int N_WAY          = `N_WAY,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEFAULT,
  localparam int CW            = $clog2(N_WAY) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CW-1:0]    req_num,
  input  logic [CW-1:0]    free_num,
  input  logic [CW-1:0]    empty_rob,
  input  logic [CW-1:0]    rs_free,
  input  logic             branch_haz,
  output logic [CW-1:0]    dispatch_num,
  output logic [N_WAY-1:0] dispatch_en,
  output logic             fetch_stall,
  output logic             flush,
  output logic [1:0]       ctrl_state
`ifdef DISPATCH_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      disp_total
`endif
);

  DISP_CTRL_STATE state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [CW-1:0]  grant;

  min4_sat #(
    .N_WAY (N_WAY),
    .CW    (CW)
  ) u_min4_sat (
    .a_i   (req_num),
    .b_i   (free_num),
    .c_i   (empty_rob),
    .d_i   (rs_free),
    .min_o (grant)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (branch_haz) state_d = FLUSH;
      end
      FLUSH: begin
        if (!branch_haz) begin
          state_d = RECOVER;
          cnt_d   = 4'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        // A new mispredict restarts the whole flush/recover sequence.
        if (branch_haz) begin
          state_d = FLUSH;
        end else if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    dispatch_num = ((state_q == RUN) && !branch_haz) ? grant : '0;
    fetch_stall  = (state_q != RUN) || branch_haz || (dispatch_num < req_num);
    flush        = (state_q == FLUSH);
    ctrl_state   = state_q;
    for (int i = 0; i < N_WAY; i++) begin
      dispatch_en[i] = (CW'(i) < dispatch_num);
    end
  end

`ifdef DISPATCH_CTRL_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] disp_total_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
      disp_total_q   <= 32'd0;
    end else begin
      if (fetch_stall && (req_num != '0)) stall_cycles_q <= stall_cycles_q + 32'd1;
      disp_total_q <= disp_total_q + 32'(dispatch_num);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign disp_total   = disp_total_q;
`endif

endmodule

`default_nettype wire

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 The module SHALL have parameter N_WAY, default `N_WAY, meaning the superscalar dispatch width.
REQ-002 The module SHALL have parameter RECOVER_CYCLES, default 2, meaning post-flush quiet cycles (legal range 1..15).
REQ-003 The module SHALL have ports, with CW = $clog2(N_WAY)+1:
- clock  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- req_num  in  CW  valid instructions offered by the dispatch stage.
- free_num  in  CW  free physical registers reported by the free list.
- empty_rob  in  CW  empty ROB slots.
- rs_free  in  CW  free reservation-station entries.
- branch_haz  in  1  mispredict recovery request from the ROB.
- dispatch_num  out  CW  granted dispatch count this cycle.
- dispatch_en  out  N_WAY  thermometer mask, bit i set iff i < dispatch_num.
- fetch_stall  out  1  holds fetch/dispatch inputs.
- flush  out  1  one-cycle pipeline flush strobe.
- ctrl_state  out  2  current FSM state (debug).

Function
REQ-004 The FSM SHALL have states INIT=0, RUN=1, FLUSH=2, RECOVER=3.
REQ-005 INIT SHALL last exactly one cycle after reset release, then go to RUN.
REQ-006 In RUN with branch_haz=0, dispatch_num SHALL equal min(req_num, free_num, empty_rob, rs_free), computed combinationally (zero latency).
REQ-007 Each of the four inputs SHALL be clamped to N_WAY before the min, so the grant never exceeds N_WAY.
REQ-008 dispatch_num SHALL be 0 in INIT, FLUSH, and RECOVER.
REQ-009 dispatch_num SHALL be 0 in any RUN cycle with branch_haz=1; branch_haz has priority over grant.
REQ-010 fetch_stall SHALL be 1 when the state is not RUN, when branch_haz=1, or when dispatch_num < req_num; otherwise 0.
REQ-011 From RUN, branch_haz=1 SHALL move the FSM to FLUSH on the next edge.
REQ-012 flush SHALL be 1 exactly while the state is FLUSH.
REQ-013 FLUSH SHALL last one cycle, then go to RECOVER, loading a 4-bit down-counter with RECOVER_CYCLES-1.
REQ-014 RECOVER SHALL decrement the counter each cycle and go to RUN in the cycle after the counter reads 0, so RECOVER lasts exactly RECOVER_CYCLES cycles.
REQ-015 branch_haz=1 in FLUSH or RECOVER SHALL re-enter FLUSH on the next edge, restarting recovery.
REQ-016 branch_haz in INIT SHALL be ignored.
REQ-017 Reset asserted mid-operation SHALL immediately force INIT, regardless of state or counter.

Reset
REQ-018 While reset=0, the module SHALL hold: ctrl_state=INIT, counter=0, dispatch_num=0, dispatch_en=0, fetch_stall=1, flush=0, stats counters=0.

Configuration
REQ-019 With DISPATCH_CTRL_STATS_EN defined, the module SHALL add outputs stall_cycles (32) and disp_total (32).
- stall_cycles SHALL increment on every cycle with fetch_stall=1 and req_num>0.
- disp_total SHALL add dispatch_num every cycle.
- Both counters SHALL wrap modulo 2^32.
REQ-020 Without DISPATCH_CTRL_STATS_EN, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-021 The state enum (DISP_CTRL_STATE) and the RECOVER_CYCLES default constant SHALL live in the shared package alongside DISPATCH_PACKET and ROB_PACKET; the CW width SHALL derive from `N_WAY.
REQ-022 The four-way clamped min SHALL be a sub-module min4_sat, instantiated once; the FSM and counters SHALL stay in dispatch_ctrl.

Verification (N_WAY=3, RECOVER_CYCLES=2)
REQ-023 Reset release with req=3, free=3, rob=3, rs=3 -> cycle 0 in INIT with dispatch_num=0 and fetch_stall=1; cycle 1 in RUN with dispatch_num=3, dispatch_en=3'b111, fetch_stall=0.
REQ-024 In RUN with req=3, free=1, rob=2, rs=3 -> dispatch_num=1, dispatch_en=3'b001, fetch_stall=1; with req=0 -> dispatch_num=0, fetch_stall=0.
REQ-025 branch_haz pulsed for one cycle in RUN -> dispatch_num=0 that cycle, flush=1 the next cycle, RECOVER for 2 cycles, RUN resumes 4 cycles after the pulse.
REQ-026 branch_haz re-asserted in the first RECOVER cycle -> FLUSH again next cycle, the counter reloads, and the RUN re-entry is delayed accordingly.
REQ-027 Reset dropped to 0 mid-RECOVER -> same-cycle ctrl_state=0, flush=0, dispatch_num=0; after release, the REQ-023 sequence repeats.
REQ-028 With DISPATCH_CTRL_STATS_EN, 10 RUN cycles at grant 2 plus 4 recovery cycles with req=3 -> disp_total=20, stall_cycles=14.
